// File: rtl/jtframe_rom_nslots.sv
// Shares one SDRAM bank among SLOTS read-only ROM slots, each with a one-entry cache.
// Hits are zero-latency; misses are served round-robin and complete the cycle after data_rdy.
module jtframe_rom_nslots #(
  parameter int                  SLOTS  = 4,
  parameter int                  AW     = 18,
  parameter logic [2*SLOTS-1:0]  DWSEL  = '0,
  parameter logic [22*SLOTS-1:0] OFFSET = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  output logic [SLOTS*32-1:0]   slot_dout,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [21:0]           sdram_addr,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  input  logic                  data_dst,
  input  logic                  data_rdy,
  input  logic [15:0]           data_read
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t            state_q;
  logic [SW-1:0]     rr_ptr_q, rr_ptr_d, sel_q, pick;
  logic [AW-1:0]     req_tag_q;
  logic [31:0]       buf_q, fill;
  logic [15:0]       lo, hi;
  logic              beat_q, is32_q, drop_q, found;
  logic              sdram_req_q;
  logic [21:0]       sdram_addr_q;
  logic [SLOTS-1:0]  valid_q, miss;
  logic [AW-1:0]     ctag_q [SLOTS];
  logic [31:0]       cdat_q [SLOTS];
  logic [AW-1:0]     addr_a [SLOTS];
  logic [21:0]       req_addr [SLOTS];
  logic [1:0]        dw [SLOTS];

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    localparam logic [1:0]  DW  = DWSEL[2*s +: 2];
    localparam logic [21:0] OFS = OFFSET[22*s +: 22];
    logic [AW-1:0] addr;
    logic [21:0]   waddr;
    logic          match;

    assign addr      = slot_addr[s*AW +: AW];
    assign addr_a[s] = addr;
    assign dw[s]     = DW;
    // 8-bit slots cache the whole 16-bit word, so bit 0 only picks the byte
    assign match = (DW == 2'd0) ? (addr[AW-1:1] == ctag_q[s][AW-1:1]) : (addr == ctag_q[s]);
    assign slot_ok[s] = slot_cs[s] & valid_q[s] & match;
    assign miss[s]    = slot_cs[s] & ~slot_ok[s];
    assign slot_dout[s*32 +: 32] =
        (DW == 2'd0) ? {24'd0, addr[0] ? cdat_q[s][15:8] : cdat_q[s][7:0]} :
        (DW == 2'd1) ? {16'd0, cdat_q[s][15:0]} : cdat_q[s];
    assign waddr = (DW == 2'd0) ? 22'(addr >> 1) :
                   (DW == 2'd1) ? 22'(addr) : 22'({addr, 1'b0});
    assign req_addr[s] = OFS + waddr;
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (!found && miss[s] && (((int'(rr_ptr_q) + k) % SLOTS) == s)) begin
          found = 1'b1;
          pick  = SW'(s);
        end
      end
    end
  end

  // Fold the beat arriving with data_rdy straight into the cache write
  always_comb begin
    lo   = (data_dst && !beat_q) ? data_read : buf_q[15:0];
    hi   = (data_dst &&  beat_q) ? data_read : buf_q[31:16];
    fill = {is32_q ? hi : 16'd0, lo};
  end

  assign rr_ptr_d   = (sel_q == SW'(SLOTS - 1)) ? '0 : sel_q + 1'b1;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      sel_q        <= '0;
      req_tag_q    <= '0;
      buf_q        <= '0;
      beat_q       <= 1'b0;
      is32_q       <= 1'b0;
      drop_q       <= 1'b0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      valid_q      <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        ctag_q[s] <= '0;
        cdat_q[s] <= '0;
      end
    end else begin
      if (flush) valid_q <= '0;
      case (state_q)
        IDLE: begin
          drop_q <= 1'b0;
          if (found) begin
            sel_q        <= pick;
            req_tag_q    <= addr_a[pick];
            sdram_addr_q <= req_addr[pick];
            sdram_req_q  <= 1'b1;
            buf_q        <= '0;
            beat_q       <= 1'b0;
            is32_q       <= (dw[pick] == 2'd2);
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (flush) drop_q <= 1'b1;
          if (sdram_ack) begin
            sdram_req_q <= 1'b0;
            state_q     <= DATA;
          end
        end
        DATA: begin
          if (flush) drop_q <= 1'b1;
          if (data_dst) begin
            if (!beat_q) buf_q[15:0]  <= data_read;
            else         buf_q[31:16] <= data_read;
            beat_q <= 1'b1;
          end
          if (data_rdy) begin
            cdat_q[sel_q] <= fill;
            ctag_q[sel_q] <= req_tag_q;
            if (!flush && !drop_q) valid_q[sel_q] <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
